// File: rtl/comparator_bist_pkg.sv
// Shared types and constants for the comparator BIST controller.
// The LFSR taps describe x^16+x^14+x^13+x^11+1 in right-shifting Galois form.
package comparator_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/comparator_bist_lfsr16.sv
// 16-bit right-shifting Galois LFSR with synchronous load and step enable.
// The output bit shifted out of bit 0 is fed back into every tap position.
module lfsr16
    import comparator_bist_pkg::*;
#(
    parameter logic [15:0] RESET_SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        enable,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_reg;
    logic [15:0] state_next;

    assign state_next[15] = state_reg[0] & LFSR_TAPS[15];

    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_tap
            assign state_next[gi] = state_reg[gi+1] ^ (state_reg[0] & LFSR_TAPS[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RESET_SEED;
        end else if (load) begin
            state_reg <= seed;
        end else if (enable) begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/comparator_bist.sv
// Built-in self test for an external magnitude comparator: drives operand pairs,
// checks the returned eq/gt/lt against an exact reference and accumulates statistics.
module comparator_bist
    import comparator_bist_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    input  logic [15:0]        n_vec,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic               dut_eq,
    input  logic               dut_gt,
    input  logic               dut_lt,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH:0]   vec_count,
    output logic [2*WIDTH:0]   err_count,
    output logic [2*WIDTH:0]   inv_count,
    output logic [WIDTH-1:0]   first_err_a,
    output logic [WIDTH-1:0]   first_err_b,
    output logic               first_err_vld
);

    localparam int VW = 2 * WIDTH;
    localparam int CW = VW + 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t            state_reg;
    logic              mode_reg;
    logic [15:0]       rem_reg;
    logic [VW-1:0]     vec_reg;
    logic [CW-1:0]     vec_count_reg;
    logic [CW-1:0]     err_count_reg;
    logic [CW-1:0]     inv_count_reg;
    logic [WIDTH-1:0]  first_err_a_reg;
    logic [WIDTH-1:0]  first_err_b_reg;
    logic              first_err_vld_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [15:0]       lfsr_state;
    logic              lfsr_load;
    logic              lfsr_enable;
    logic [WIDTH-1:0]  rnd_a;
    logic [WIDTH-1:0]  rnd_b;
    logic [WIDTH-1:0]  cur_a;
    logic [WIDTH-1:0]  cur_b;
    logic [2:0]        ref_res;
    logic [2:0]        dut_res;
    logic              mismatch;
    logic              not_one_hot;
    logic              last_vec;
    logic              start_ok;

    lfsr16 #(
        .RESET_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (lfsr_load),
        .enable (lfsr_enable),
        .seed   (LFSR_SEED),
        .state  (lfsr_state)
    );

    // Random operands come from the top and bottom LFSR bytes; wider operands zero-extend.
    generate
        if (WIDTH <= 8) begin : g_rnd_narrow
            assign rnd_a = lfsr_state[15 -: WIDTH];
            assign rnd_b = lfsr_state[7 -: WIDTH];
        end else begin : g_rnd_wide
            assign rnd_a = {{(WIDTH-8){1'b0}}, lfsr_state[15:8]};
            assign rnd_b = {{(WIDTH-8){1'b0}}, lfsr_state[7:0]};
        end
    endgenerate

    // Operands read as zero until the first run so reset leaves the comparator inputs at 0.
    always_comb begin
        cur_a = vec_reg[VW-1:WIDTH];
        cur_b = vec_reg[WIDTH-1:0];
        if (mode_reg) begin
            cur_a = rnd_a;
            cur_b = rnd_b;
        end
        if (state_reg == ST_IDLE) begin
            cur_a = '0;
            cur_b = '0;
        end
    end

    assign a_out = cur_a;
    assign b_out = cur_b;

    assign ref_res     = {cur_a == cur_b, cur_a > cur_b, cur_a < cur_b};
    assign dut_res     = {dut_eq, dut_gt, dut_lt};
    assign mismatch    = (dut_res != ref_res);
    assign not_one_hot = !((dut_res == 3'b100) || (dut_res == 3'b010) || (dut_res == 3'b001));

    assign last_vec    = mode_reg ? (rem_reg == 16'd0) : (&vec_reg);
    assign start_ok    = start && (state_reg != ST_RUN);
    assign lfsr_load   = start_ok;
    // The final vector is held rather than advanced so it stays visible in DONE.
    assign lfsr_enable = (state_reg == ST_RUN) && mode_reg && !last_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_IDLE;
            mode_reg          <= 1'b0;
            rem_reg           <= '0;
            vec_reg           <= '0;
            vec_count_reg     <= '0;
            err_count_reg     <= '0;
            inv_count_reg     <= '0;
            first_err_a_reg   <= '0;
            first_err_b_reg   <= '0;
            first_err_vld_reg <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_reg          <= mode;
                        rem_reg           <= n_vec - 16'd1;
                        vec_reg           <= '0;
                        vec_count_reg     <= '0;
                        err_count_reg     <= '0;
                        inv_count_reg     <= '0;
                        first_err_a_reg   <= '0;
                        first_err_b_reg   <= '0;
                        first_err_vld_reg <= 1'b0;
                        // An empty random run has nothing to check and finishes immediately.
                        if (mode && (n_vec == 16'd0)) begin
                            state_reg <= ST_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_RUN;
                            busy_reg  <= 1'b1;
                            done_reg  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (vec_count_reg != CNT_MAX) begin
                        vec_count_reg <= vec_count_reg + 1'b1;
                    end
                    if (mismatch && (err_count_reg != CNT_MAX)) begin
                        err_count_reg <= err_count_reg + 1'b1;
                    end
                    if (not_one_hot && (inv_count_reg != CNT_MAX)) begin
                        inv_count_reg <= inv_count_reg + 1'b1;
                    end
                    if (mismatch && !first_err_vld_reg) begin
                        first_err_a_reg   <= cur_a;
                        first_err_b_reg   <= cur_b;
                        first_err_vld_reg <= 1'b1;
                    end
                    if (last_vec) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        vec_reg <= vec_reg + 1'b1;
                        rem_reg <= rem_reg - 16'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_reg;
    assign done          = done_reg;
    assign vec_count     = vec_count_reg;
    assign err_count     = err_count_reg;
    assign inv_count     = inv_count_reg;
    assign first_err_a   = first_err_a_reg;
    assign first_err_b   = first_err_b_reg;
    assign first_err_vld = first_err_vld_reg;

endmodule

// File: tb/tb_comparator_bist.sv
// Randomized scoreboard bench for comparator_bist with a behavioural comparator
// (exact or faulty) and a whole-run reference model.
module tb_comparator_bist;

    localparam int          W    = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           mode = 1'b0;
    logic [15:0]    n_vec = '0;
    logic [W-1:0]   a_out, b_out, first_err_a, first_err_b;
    logic           dut_eq, dut_gt, dut_lt, busy, done, first_err_vld;
    logic [2*W:0]   vec_count, err_count, inv_count;
    int             fault_sel = 0;

    int vec_applied = 0;
    int miscompares = 0;

    typedef struct {
        string        name;
        int           vecs;
        int           errs;
        int           invs;
        int           busy_cycles;
        bit           fvld;
        logic [W-1:0] fa, fb, la, lb;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    comparator_bist #(.WIDTH(W), .LFSR_SEED(SEED)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mode          (mode),
        .n_vec         (n_vec),
        .a_out         (a_out),
        .b_out         (b_out),
        .dut_eq        (dut_eq),
        .dut_gt        (dut_gt),
        .dut_lt        (dut_lt),
        .busy          (busy),
        .done          (done),
        .vec_count     (vec_count),
        .err_count     (err_count),
        .inv_count     (inv_count),
        .first_err_a   (first_err_a),
        .first_err_b   (first_err_b),
        .first_err_vld (first_err_vld)
    );

    // Comparator under test: 0 exact, 1 eq stuck at 0, 2 ignores operand bit 0.
    function automatic logic [2:0] cut(input int f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-2:0] ah, bh;
        ah = a[W-1:1];
        bh = b[W-1:1];
        case (f)
            1:       return {1'b0, a > b, a < b};
            2:       return {ah == bh, ah > bh, ah < bh};
            default: return {a == b, a > b, a < b};
        endcase
    endfunction

    assign {dut_eq, dut_gt, dut_lt} = cut(fault_sel, a_out, b_out);

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        vec_applied++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: enumerate the vectors of a run and score each against the comparator model.
    task automatic build_expect(input bit md, input int nvec, input int fault, input string name);
        exp_t         e;
        logic [15:0]  x;
        logic [W-1:0] a, b;
        logic [2:0]   r, exact;
        int           total;
        total = md ? nvec : (1 << (2 * W));
        x = SEED;
        e.name = name;
        e.errs = 0;
        e.invs = 0;
        e.fvld = 1'b0;
        e.fa = '0;
        e.fb = '0;
        e.la = md ? x[15 -: W] : '0;
        e.lb = md ? x[7 -: W] : '0;
        for (int i = 0; i < total; i++) begin
            if (md) begin
                a = x[15 -: W];
                b = x[7 -: W];
                x = lfsr_next(x);
            end else begin
                a = W'(i >> W);
                b = W'(i);
            end
            r = cut(fault, a, b);
            exact = {a == b, a > b, a < b};
            if (r != exact) begin
                e.errs++;
                if (!e.fvld) begin
                    e.fvld = 1'b1;
                    e.fa = a;
                    e.fb = b;
                end
            end
            if ($countones(r) != 1) e.invs++;
            e.la = a;
            e.lb = b;
        end
        e.vecs = total;
        e.busy_cycles = total;
        exp_q.push_back(e);
    endtask

    task automatic check_reset(input string nm);
        check({nm, ".busy"}, busy, 0);
        check({nm, ".done"}, done, 0);
        check({nm, ".vec_count"}, vec_count, 0);
        check({nm, ".err_count"}, err_count, 0);
        check({nm, ".inv_count"}, inv_count, 0);
        check({nm, ".a_out"}, a_out, 0);
        check({nm, ".b_out"}, b_out, 0);
        check({nm, ".first_err_a"}, first_err_a, 0);
        check({nm, ".first_err_b"}, first_err_b, 0);
        check({nm, ".first_err_vld"}, first_err_vld, 0);
    endtask

    task automatic run(input bit md, input int nvec, input int fault, input int glitch_at);
        string nm;
        int    limit;
        nm = $sformatf("%s_n%0d_f%0d", md ? "rnd" : "exh", nvec, fault);
        fault_sel = fault;
        build_expect(md, nvec, fault, nm);
        @(negedge clk);
        start = 1'b1;
        mode  = md;
        n_vec = nvec[15:0];
        @(negedge clk);
        start = 1'b0;
        mode  = 1'($urandom);
        n_vec = 16'($urandom);
        if (md && nvec == 0) check({nm, ".done_after_1"}, done, 1);
        if (glitch_at > 0) begin
            repeat (glitch_at) @(negedge clk);
            start = 1'b1;
            mode  = ~md;
            n_vec = 16'd3;
            @(negedge clk);
            start = 1'b0;
        end
        limit = (md ? nvec : (1 << (2 * W))) + 20;
        for (int c = 0; c < limit && exp_q.size() != 0; c++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check({nm, ".timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Monitor: each rising done retires one expected run from the scoreboard.
    initial begin : monitor
        exp_t e;
        int   done_prev;
        int   busy_cyc;
        done_prev = 0;
        busy_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cyc = 0;
                done_prev = 0;
            end else begin
                if (busy) busy_cyc++;
                if (done && done_prev == 0) begin
                    if (exp_q.size() == 0) begin
                        check("mon.unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, ".vec_count"}, vec_count, e.vecs);
                        check({e.name, ".err_count"}, err_count, e.errs);
                        check({e.name, ".inv_count"}, inv_count, e.invs);
                        check({e.name, ".first_err_vld"}, first_err_vld, e.fvld);
                        check({e.name, ".first_err_a"}, first_err_a, e.fa);
                        check({e.name, ".first_err_b"}, first_err_b, e.fb);
                        check({e.name, ".last_a"}, a_out, e.la);
                        check({e.name, ".last_b"}, b_out, e.lb);
                        check({e.name, ".busy_cycles"}, busy_cyc, e.busy_cycles);
                        $display("run %s: vec=%0d err=%0d inv=%0d first=%0d a=%02h b=%02h",
                                 e.name, vec_count, err_count, inv_count, first_err_vld,
                                 first_err_a, first_err_b);
                    end
                    busy_cyc = 0;
                end
                done_prev = done ? 1 : 0;
            end
        end
    end

    initial begin : stimulus
        int c;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle.no_autostart_busy", busy, 0);
        check("idle.no_autostart_vec", vec_count, 0);

        run(1'b1, 0, 0, 0);
        run(1'b1, 1000, 0, 0);
        run(1'b1, 700, 1, 250);
        run(1'b1, int'($urandom_range(50, 400)), 2, 0);
        run(1'b1, int'($urandom_range(100, 600)), 1, 0);

        // Asynchronous reset in the middle of a random run.
        fault_sel = 1;
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b1;
        n_vec = 16'd1000;
        @(negedge clk);
        start = 1'b0;
        for (c = 0; c < 300 && vec_count != 100; c++) @(negedge clk);
        check("rst_mid.reach100", vec_count, 100);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid.stays_idle", busy, 0);

        run(1'b1, 300, 1, 0);
        run(1'b0, 0, 2, 0);
        run(1'b1, 200, 0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard.drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/comparator_bist.md
COMPARATOR_BIST -- requirements
Module: comparator_bist

Interface
REQ-001 Parameter WIDTH, default 8: operand width of the comparator under test; vector space is 2^(2*WIDTH).
REQ-002 Parameter LFSR_SEED, default 16'hACE1: nonzero random-mode seed.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin a run; honoured only in IDLE or DONE.
REQ-006 mode  input  1  0 = exhaustive sweep, 1 = LFSR random; sampled with start.
REQ-007 n_vec  input  16  random-mode vector count; sampled with start.
REQ-008 a_out, b_out  output  WIDTH  operands driven to the comparator under test.
REQ-009 dut_eq, dut_gt, dut_lt  input  1 each  comparator results, combinational from a_out/b_out.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  high in DONE.
REQ-012 vec_count  output  2*WIDTH+1  vectors checked.
REQ-013 err_count  output  2*WIDTH+1  vectors where {eq,gt,lt} differs from exact.
REQ-014 inv_count  output  2*WIDTH+1  vectors where {eq,gt,lt} is not one-hot.
REQ-015 first_err_a, first_err_b  output  WIDTH each  operands of first mismatching vector; first_err_vld  output  1.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN or DONE->RUN on start; RUN->DONE after the last check; start ignored in RUN.
REQ-017 On start: clear all counters and first_err_*; load first vector ({a,b}=0 exhaustive; {a,b}=LFSR_SEED random); latch mode and n_vec.
REQ-018 Each RUN cycle: reference = (a_out==b_out, a_out>b_out, a_out<b_out) unsigned; compare with DUT inputs at the clock edge; update counters; advance vector the same edge.
REQ-019 Exhaustive order: {a_out,b_out} increments by 1, b in LSBs; last vector {a,b} all ones; exactly 2^(2*WIDTH) RUN cycles.
REQ-020 Random: Galois LFSR x^16+x^14+x^13+x^11+1, a_out=lfsr[15:8], b_out=lfsr[7:0]; exactly n_vec RUN cycles; n_vec=0 -> RUN for 0 cycles, DONE one cycle after start, counts 0.
REQ-021 A vector both mismatching and non-one-hot increments err_count and inv_count.
REQ-022 first_err_* captured only on first mismatch of a run; held until next start.
REQ-023 Counters are wide enough never to wrap; saturate at all-ones regardless.
REQ-024 DONE holds done=1 and all results stable until start.
REQ-025 a_out/b_out hold last vector in DONE.

Reset
REQ-026 rst_n low, at any time including mid-RUN: state IDLE, busy=0, done=0, all counters 0, a_out=b_out=0, first_err_*=0, first_err_vld=0, LFSR=LFSR_SEED.
REQ-027 After release, no run starts without a new start pulse.

Structure
REQ-028 Package comparator_bist_pkg: state enum, LFSR tap constant, default seed.
REQ-029 One sub-module lfsr16 (load, enable, seed, state out).
REQ-030 Reference comparison and counters in the top module; comparator under test external.

Verification
REQ-031 Exact 8-bit comparator, mode 0 -> done after 65536 RUN cycles, vec_count=65536, err_count=0, inv_count=0, first_err_vld=0.
REQ-032 DUT with eq stuck at 0, mode 0 -> err_count=256, inv_count=256, first_err a=0,b=0.
REQ-033 Approximate DUT ignoring bit 0, mode 0 -> err_count=256, inv_count=0, first_err a=0x00,b=0x01.
REQ-034 Mode 1, n_vec=1000, exact DUT -> vec_count=1000, err_count=0; first vector a=0xAC,b=0xE1; n_vec=0 -> done one cycle after start.
REQ-035 rst_n low at vec_count=100 -> all outputs zero asynchronously, IDLE; new start gives full clean run.
REQ-036 start pulses during RUN ignored; start in DONE restarts with cleared counters.
